// File: rtl/froc_test_pkg.sv
// Shared types and width constants for the FRoC test sequencer and its sink checker.
package froc_test_pkg;

  localparam int unsigned FROC_STATE_W   = 4;
  localparam int unsigned FROC_NUM_SINKS = 8;
  localparam int unsigned FROC_ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_CAPTURE,
    S_COMPARE,
    S_NEXT,
    S_DONE
  } seq_state_e;

  // Run outcome as seen by reporting logic, at the default widths.
  typedef struct packed {
    logic                      pass;
    logic [FROC_ERR_CNT_W-1:0] err_count;
    logic                      first_fail_valid;
    logic [FROC_STATE_W-1:0]   first_fail_state;
    logic [FROC_NUM_SINKS-1:0] mismatch_mask;
  } froc_result_t;

endpackage

// File: rtl/froc_sink_checker.sv
// Captures sink/golden pairs, compares them and keeps the error count and first-fail record.
module froc_sink_checker
  import froc_test_pkg::*;
#(
  parameter int unsigned STATE_W = FROC_STATE_W,
  parameter int unsigned SINK_W  = FROC_NUM_SINKS,
  parameter int unsigned ERR_W   = FROC_ERR_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               sample,
  input  logic               compare,
  input  logic [STATE_W-1:0] state,
  input  logic [SINK_W-1:0]  sinks_in,
  input  logic [SINK_W-1:0]  exp_sinks,
  output logic [ERR_W-1:0]   err_count,
  output logic               first_fail_valid,
  output logic [STATE_W-1:0] first_fail_state,
  output logic [SINK_W-1:0]  mismatch_mask
);

  logic [SINK_W-1:0] cap_sinks;
  logic [SINK_W-1:0] cap_exp;
  logic [SINK_W-1:0] diff_c;

  assign diff_c = cap_sinks ^ cap_exp;

  // Capture registers: only loaded on the sample strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_sinks <= '0;
      cap_exp   <= '0;
    end else if (clear) begin
      cap_sinks <= '0;
      cap_exp   <= '0;
    end else if (sample) begin
      cap_sinks <= sinks_in;
      cap_exp   <= exp_sinks;
    end
  end

  // Saturating error count and sticky first-fail record.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_state <= '0;
      mismatch_mask    <= '0;
    end else if (clear) begin
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_state <= '0;
      mismatch_mask    <= '0;
    end else if (compare && (diff_c != '0)) begin
      if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (!first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_state <= state;
        mismatch_mask    <= diff_c;
      end
    end
  end

endmodule

// File: rtl/froc_test_sequencer.sv
// Walks the FRoC state vector through a test run: launch, settle, capture, compare per state.
module froc_test_sequencer
  import froc_test_pkg::*;
#(
  parameter int unsigned STATE_LENGTH  = FROC_STATE_W,
  parameter int unsigned NUM_SINKS     = FROC_NUM_SINKS,
  parameter int unsigned NUM_STATES    = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = FROC_ERR_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [STATE_LENGTH-1:0] state_out,
  output logic                    launch,
  output logic                    capture,
  input  logic [NUM_SINKS-1:0]    sinks_in,
  input  logic [NUM_SINKS-1:0]    exp_sinks,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic                    first_fail_valid,
  output logic [STATE_LENGTH-1:0] first_fail_state,
  output logic [NUM_SINKS-1:0]    mismatch_mask
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [STATE_LENGTH-1:0] LAST_STATE = STATE_LENGTH'(NUM_STATES - 1);

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [STATE_LENGTH-1:0] state_out_d;
  logic                    launch_d, capture_d, busy_d, done_d, pass_d;
  logic                    clear_c, sample_c, compare_c;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      state_out <= '0;
      launch    <= 1'b0;
      capture   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      state_out <= state_out_d;
      launch    <= launch_d;
      capture   <= capture_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
    end
  end

  // Next state; launch/capture are set on entry so they are high exactly while in that state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    state_out_d = state_out;
    launch_d    = 1'b0;
    capture_d   = 1'b0;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;
    clear_c     = 1'b0;
    sample_c    = 1'b0;
    compare_c   = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            clear_c     = 1'b1;
            state_out_d = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            launch_d    = 1'b1;
            state_d     = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_d = CNT_W'(SETTLE_CYCLES);
          if (SETTLE_CYCLES > 0) begin
            state_d = S_SETTLE;
          end else begin
            capture_d = 1'b1;
            state_d   = S_CAPTURE;
          end
        end
        S_SETTLE: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            capture_d = 1'b1;
            state_d   = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          sample_c = 1'b1;
          state_d  = S_COMPARE;
        end
        S_COMPARE: begin
          compare_c = 1'b1;
          state_d   = S_NEXT;
        end
        S_NEXT: begin
          if (state_out == LAST_STATE) begin
            done_d  = 1'b1;
            pass_d  = (err_count == '0);
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_out_d = state_out + STATE_LENGTH'(1);
            launch_d    = 1'b1;
            state_d     = S_LAUNCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  froc_sink_checker #(
    .STATE_W (STATE_LENGTH),
    .SINK_W  (NUM_SINKS),
    .ERR_W   (ERR_CNT_W)
  ) u_checker (
    .clk              (clk),
    .reset_n          (reset_n),
    .clear            (clear_c),
    .sample           (sample_c),
    .compare          (compare_c),
    .state            (state_out),
    .sinks_in         (sinks_in),
    .exp_sinks        (exp_sinks),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_state (first_fail_state),
    .mismatch_mask    (mismatch_mask)
  );

endmodule
